sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO built on a registered-read dual-port RAM.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/sync_dp_ram.sv | 29 ++
 rtl/sync_fifo_param.sv | 101 ++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth helper, default pointer type, error-flag bit positions.
// Used by both the same-clock and async FIFO paths.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int FIFO_ADDR_W = 4;
  typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

endpackage

// File: rtl/sync_dp_ram.sv
// Single-clock dual-port RAM; read data registered when re is high, 1-clock latency.
// Same-address read/write in one cycle returns the old word.
module sync_dp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; contents are discarded by pointer reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost-full/empty and sticky error flags; 1-clock read latency.
// Writes while full and reads while empty are dropped and latch overflow/underflow.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t AF_LVL = ptr_t'(AFULL_THRESH);
  localparam ptr_t AE_LVL = ptr_t'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1 ||
      AEMPTY_THRESH < 1 || AEMPTY_THRESH > DEPTH - 1 ||
      AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_thresh
    $error("sync_fifo_param: thresholds must lie in 1..DEPTH-1 with AEMPTY_THRESH < AFULL_THRESH");
  end

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_set;

  // Extra pointer MSB distinguishes full from empty when the RAM indices match.
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ptr_t'(1);
      rd_valid <= rd_acc;
    end
  end

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = wr_en && full;
    err_set[ERR_UDF] = rd_en && empty;
  end

  // A new error in the same cycle as clr_err survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= (clr_err ? '0 : err_q) | err_set;
  end

  assign overflow  = err_q[ERR_OVF];
  assign underflow = err_q[ERR_UDF];

  sync_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  always #5 clk = ~clk;

  sync_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents as a queue, outputs from the rules on occupancy.
  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  logic       m_rd_valid;
  logic       m_ovf;
  logic       m_udf;
  int         m_n;
  bit         m_wok;
  bit         m_rok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      m_n   = q.size();
      m_wok = wr_en && (m_n < DEPTH);
      m_rok = rd_en && (m_n > 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (wr_en && m_n == DEPTH) m_ovf = 1'b1;
      if (rd_en && m_n == 0)     m_udf = 1'b1;
      m_rd_valid = m_rok;
      if (m_rok) m_rd_data = q.pop_front();
      if (m_wok) q.push_back(wr_data);
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("count",        32'(count),        32'(q.size()));
      check("full",         32'(full),         32'(q.size() == DEPTH));
      check("empty",        32'(empty),        32'(q.size() == 0));
      check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      check("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
      check("rd_data",      32'(rd_data),      32'(m_rd_data));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_udf));
    end
  end

  // Apply inputs for one cycle; returns at the following falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    chk_en  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset / idle
    step(0, 8'h00, 0, 0);
    check("t1_count",    32'(count),        32'd0);
    check("t1_empty",    32'(empty),        32'd1);
    check("t1_aempty",   32'(almost_empty), 32'd1);
    check("t1_rd_valid", 32'(rd_valid),     32'd0);
    check("t1_rd_data",  32'(rd_data),      32'h00);

    // 2: single word
    step(1, 8'hA5, 0, 0);
    check("t2_count1",   32'(count),    32'd1);
    step(0, 8'h00, 1, 0);
    check("t2_count0",   32'(count),    32'd0);
    check("t2_rd_valid", 32'(rd_valid), 32'd1);
    check("t2_rd_data",  32'(rd_data),  32'hA5);
    step(0, 8'h00, 0, 0);
    check("t2_rd_valid_drop", 32'(rd_valid), 32'd0);

    // 3: fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 10) check("t3_af_before", 32'(almost_full), 32'd0);
      if (i == 11) check("t3_af_after",  32'(almost_full), 32'd1);
      if (i == 14) check("t3_full_before", 32'(full), 32'd0);
    end
    check("t3_full",  32'(full),  32'd1);
    step(1, 8'hFF, 0, 0);
    check("t3_ovf",   32'(overflow), 32'd1);
    check("t3_count", 32'(count),    32'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      check("t3_drain", 32'(rd_data), 32'(i));
    end
    step(0, 8'h00, 0, 1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: simultaneous ops at full and at empty
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'hEE, 1, 0);
    check("t4_full_rd_data", 32'(rd_data),  32'h40);
    check("t4_full_valid",   32'(rd_valid), 32'd1);
    check("t4_full_count",   32'(count),    32'd15);
    check("t4_full_ovf",     32'(overflow), 32'd1);
    while (!empty) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h77, 1, 0);
    check("t4_empty_valid", 32'(rd_valid),  32'd0);
    check("t4_empty_count", 32'(count),     32'd1);
    check("t4_empty_udf",   32'(underflow), 32'd1);
    step(0, 8'h00, 1, 0);
    check("t4_empty_word",  32'(rd_data),   32'h77);

    // 5: sustained read+write at count 5 wraps both pointers
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h85 + i), 1, 0);
    check("t5_count",   32'(count),   32'd5);
    check("t5_rd_data", 32'(rd_data), 32'hA7);
    while (!empty) step(0, 8'h00, 1, 0);

    // clear vs set in same cycle
    step(0, 8'h00, 0, 1);
    check("clr_udf_clear", 32'(underflow), 32'd0);
    step(0, 8'h00, 1, 1);
    check("clr_udf_setwins", 32'(underflow), 32'd1);

    // 6: async reset mid-read with 9 words stored
    for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    check("t6_pre_count", 32'(count), 32'd9);
    rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count",  32'(count),        32'd0);
    check("t6_rst_empty",  32'(empty),        32'd1);
    check("t6_rst_ae",     32'(almost_empty), 32'd1);
    check("t6_rst_full",   32'(full),         32'd0);
    check("t6_rst_af",     32'(almost_full),  32'd0);
    check("t6_rst_valid",  32'(rd_valid),     32'd0);
    check("t6_rst_data",   32'(rd_data),      32'h00);
    check("t6_rst_udf",    32'(underflow),    32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    step(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    step(1, 8'h3C, 0, 0);
    step(1, 8'h3D, 0, 0);
    step(0, 8'h00, 1, 0);
    check("t6_first_word", 32'(rd_data), 32'h3C);

    // Randomised traffic with phases biased toward full and toward empty
    for (int blk = 0; blk < 8; blk++) begin
      int wb;
      int rb;
      wb = (blk % 2 == 0) ? 80 : 30;
      rb = (blk % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 99) < wb, 8'($urandom),
             $urandom_range(0, 99) < rb, $urandom_range(0, 31) == 0);
      end
    end
    step(0, 8'h00, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
